// File: rtl/qea_engine.sv
`default_nettype none
// ============================================================================
// Module   : qea_engine
// Purpose  : Quantum-circuit emulation engine. Runs a gate program from the
//            context RAM against a 2^n complex state vector in Q2.30.
// Revision : 1.0 - initial release
// ============================================================================
module qea_engine #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
    parameter int GATE_ADDR_WIDTH         = 6,
    parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_ctx_en,
    input  logic                                 i_ctx_wea,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_state_ena,
    input  logic                                 i_state_wea,
    input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
    output logic                                 o_complete,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);
    localparam int c_KW    = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int c_ROW_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int c_HB    = GATE_CONTEXT_DATA_WIDTH - 1;
    localparam int c_SUM_W = 2*ALU_DATA_WIDTH + 2;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_EXEC  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [2:0] c_ST_SCAN  = 3'd0;
    localparam logic [2:0] c_ST_CAP_K = 3'd1;
    localparam logic [2:0] c_ST_CAP_J = 3'd2;
    localparam logic [2:0] c_ST_WR_K  = 3'd3;
    localparam logic [2:0] c_ST_WR_J  = 3'd4;

    logic [1:0]                         r_state_q, w_state_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_ptr_q, w_ctx_ptr_d;
    logic [GATE_ADDR_WIDTH-1:0]         r_fetch_cnt_q, w_fetch_cnt_d;
    logic [MAX_QBIT_WIDTH-1:0]          r_qbit_num_q, w_qbit_num_d;
    logic [MAX_QBIT_WIDTH-1:0]          r_tgt_q, w_tgt_d, r_ctl_q, w_ctl_d;
    logic                               r_ctl_en_q, w_ctl_en_d;
    logic [GATE_DATA_WIDTH-1:0]         r_coef_q [0:3];
    logic [GATE_DATA_WIDTH-1:0]         w_coef_d [0:3];
    logic [c_KW:0]                      r_k_q, w_k_d;
    logic [2:0]                         r_step_q, w_step_d;
    logic [c_ROW_W-1:0]                 r_row_k_q, w_row_k_d, r_row_j_q, w_row_j_d;
    logic                               r_complete_q, w_complete_d;

    logic [c_ROW_W-1:0]                 r_state_ram [0:(1<<STATE_ADDR_WIDTH)-1];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_ram   [0:(1<<GATE_CONTEXT_ADDR_WIDTH)-1];
    logic [c_ROW_W-1:0]                 r_eng_rd_q, r_dout_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_rd_q;

    logic                               w_busy, w_mem_we, w_ctx_we, w_hdr_gate;
    logic [STATE_ADDR_WIDTH-1:0]        w_eng_raddr, w_mem_waddr, w_k_row, w_j_row;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] w_ctx_raddr;
    logic [c_ROW_W-1:0]                 w_mem_wdata, w_row_k_new, w_row_j_new;
    logic [c_KW:0]                      w_tmask, w_cmask, w_k_end;
    logic [c_KW-1:0]                    w_j;
    logic [PE_NUM_WIDTH-1:0]            w_k_lane, w_j_lane;
    logic                               w_pair_ok, w_k_done, w_same_row;
    logic [STATE_DATA_WIDTH-1:0]        w_amp_k, w_amp_j, w_a0, w_a1;
    logic [1:0]                         w_coef_idx;

    function automatic logic signed [c_SUM_W-1:0] mul(input logic signed [ALU_DATA_WIDTH-1:0] a,
                                                      input logic signed [ALU_DATA_WIDTH-1:0] b);
        logic signed [2*ALU_DATA_WIDTH-1:0] p;
        p = (2*ALU_DATA_WIDTH)'(a) * (2*ALU_DATA_WIDTH)'(b);
        return c_SUM_W'(p);
    endfunction

    // Full-precision sum of both complex products, then floor-shift and wrap.
    function automatic logic [STATE_DATA_WIDTH-1:0] cmac(input logic [GATE_DATA_WIDTH-1:0] u0,
                                                         input logic [STATE_DATA_WIDTH-1:0] x0,
                                                         input logic [GATE_DATA_WIDTH-1:0] u1,
                                                         input logic [STATE_DATA_WIDTH-1:0] x1);
        logic signed [c_SUM_W-1:0] s_re, s_im;
        s_re = mul(u0[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH], x0[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH])
             - mul(u0[ALU_DATA_WIDTH-1:0], x0[ALU_DATA_WIDTH-1:0])
             + mul(u1[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH], x1[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH])
             - mul(u1[ALU_DATA_WIDTH-1:0], x1[ALU_DATA_WIDTH-1:0]);
        s_im = mul(u0[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH], x0[ALU_DATA_WIDTH-1:0])
             + mul(u0[ALU_DATA_WIDTH-1:0], x0[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH])
             + mul(u1[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH], x1[ALU_DATA_WIDTH-1:0])
             + mul(u1[ALU_DATA_WIDTH-1:0], x1[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH]);
        return {ALU_DATA_WIDTH'(s_re >>> NUM_FRAC_BIT), ALU_DATA_WIDTH'(s_im >>> NUM_FRAC_BIT)};
    endfunction

    function automatic logic [STATE_DATA_WIDTH-1:0] lane_get(input logic [c_ROW_W-1:0] row,
                                                             input logic [PE_NUM_WIDTH-1:0] lane);
        lane_get = '0;
        for (int l = 0; l < PE_NUM; l++)
            if (lane == PE_NUM_WIDTH'(l)) lane_get = row[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
    endfunction

    function automatic logic [c_ROW_W-1:0] lane_set(input logic [c_ROW_W-1:0] row,
                                                    input logic [PE_NUM_WIDTH-1:0] lane,
                                                    input logic [STATE_DATA_WIDTH-1:0] amp);
        lane_set = row;
        for (int l = 0; l < PE_NUM; l++)
            if (lane == PE_NUM_WIDTH'(l)) lane_set[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = amp;
    endfunction

    always_comb begin : p_alu
        w_tmask     = (c_KW+1)'(1) << r_tgt_q;
        w_cmask     = (c_KW+1)'(1) << r_ctl_q;
        w_k_end     = (c_KW+1)'(1) << r_qbit_num_q;
        w_j         = r_k_q[c_KW-1:0] | w_tmask[c_KW-1:0];
        w_k_row     = r_k_q[c_KW-1:PE_NUM_WIDTH];
        w_j_row     = w_j[c_KW-1:PE_NUM_WIDTH];
        w_k_lane    = r_k_q[PE_NUM_WIDTH-1:0];
        w_j_lane    = w_j[PE_NUM_WIDTH-1:0];
        w_same_row  = (w_k_row == w_j_row);
        w_k_done    = (r_k_q >= w_k_end);
        w_pair_ok   = ~|(r_k_q & w_tmask) && (!r_ctl_en_q || |(r_k_q & w_cmask));
        w_hdr_gate  = (r_ctx_rd_q[c_HB -: 4] == 4'd1);
        w_coef_idx  = r_fetch_cnt_q[1:0] - 2'd2;
        w_amp_k     = lane_get(r_row_k_q, w_k_lane);
        w_amp_j     = lane_get(r_row_j_q, w_j_lane);
        w_a0        = cmac(r_coef_q[0], w_amp_k, r_coef_q[1], w_amp_j);
        w_a1        = cmac(r_coef_q[2], w_amp_k, r_coef_q[3], w_amp_j);
        w_row_k_new = lane_set(r_row_k_q, w_k_lane, w_a0);
        // Both halves of the pair in one row must land in a single write.
        if (w_same_row) w_row_k_new = lane_set(w_row_k_new, w_j_lane, w_a1);
        w_row_j_new = w_same_row ? w_row_k_new : lane_set(r_row_j_q, w_j_lane, w_a1);
    end

    always_comb begin : p_next_state
        w_state_d = r_state_q;
        case (r_state_q)
            c_S_IDLE:  if (i_start) w_state_d = c_S_FETCH;
            c_S_FETCH: begin
                if (r_fetch_cnt_q == GATE_ADDR_WIDTH'(1) && !w_hdr_gate) w_state_d = c_S_DONE;
                else if (r_fetch_cnt_q == GATE_ADDR_WIDTH'(5))          w_state_d = c_S_EXEC;
            end
            c_S_EXEC:  if (r_step_q == c_ST_SCAN && w_k_done) w_state_d = c_S_FETCH;
            default:   w_state_d = i_start ? c_S_FETCH : c_S_IDLE;
        endcase
    end

    always_comb begin : p_datapath
        w_ctx_ptr_d   = r_ctx_ptr_q;
        w_fetch_cnt_d = r_fetch_cnt_q;
        w_qbit_num_d  = r_qbit_num_q;
        w_tgt_d       = r_tgt_q;
        w_ctl_d       = r_ctl_q;
        w_ctl_en_d    = r_ctl_en_q;
        w_coef_d      = r_coef_q;
        w_k_d         = r_k_q;
        w_step_d      = r_step_q;
        w_row_k_d     = r_row_k_q;
        w_row_j_d     = r_row_j_q;
        w_complete_d  = r_complete_q;
        case (r_state_q)
            c_S_FETCH: begin
                w_fetch_cnt_d = r_fetch_cnt_q + GATE_ADDR_WIDTH'(1);
                if (r_fetch_cnt_q == GATE_ADDR_WIDTH'(1)) begin
                    w_tgt_d      = r_ctx_rd_q[c_HB-4 -: MAX_QBIT_WIDTH];
                    w_ctl_en_d   = r_ctx_rd_q[c_HB-4-MAX_QBIT_WIDTH];
                    w_ctl_d      = r_ctx_rd_q[c_HB-5-MAX_QBIT_WIDTH -: MAX_QBIT_WIDTH];
                    w_complete_d = !w_hdr_gate;
                end
                if (r_fetch_cnt_q >= GATE_ADDR_WIDTH'(2)) w_coef_d[w_coef_idx] = r_ctx_rd_q;
                w_k_d    = '0;
                w_step_d = c_ST_SCAN;
            end
            c_S_EXEC: begin
                case (r_step_q)
                    c_ST_SCAN: begin
                        if (w_k_done) begin
                            w_ctx_ptr_d   = r_ctx_ptr_q + GATE_CONTEXT_ADDR_WIDTH'(5);
                            w_fetch_cnt_d = '0;
                        end else if (w_pair_ok) w_step_d = c_ST_CAP_K;
                        else                    w_k_d    = r_k_q + (c_KW+1)'(1);
                    end
                    c_ST_CAP_K: begin w_row_k_d = r_eng_rd_q; w_step_d = c_ST_CAP_J; end
                    c_ST_CAP_J: begin w_row_j_d = r_eng_rd_q; w_step_d = c_ST_WR_K;  end
                    c_ST_WR_K:  w_step_d = c_ST_WR_J;
                    default: begin w_step_d = c_ST_SCAN; w_k_d = r_k_q + (c_KW+1)'(1); end
                endcase
            end
            default: begin
                if (i_start) begin
                    w_ctx_ptr_d   = '0;
                    w_fetch_cnt_d = '0;
                    w_complete_d  = 1'b0;
                    w_qbit_num_d  = i_qbit_num;
                end
            end
        endcase
    end

    always_comb begin : p_outputs
        w_busy      = (r_state_q == c_S_FETCH) || (r_state_q == c_S_EXEC);
        w_ctx_raddr = r_ctx_ptr_q + GATE_CONTEXT_ADDR_WIDTH'(r_fetch_cnt_q);
        w_ctx_we    = !rst && !w_busy && i_ctx_en && i_ctx_wea;
        w_eng_raddr = (r_step_q == c_ST_CAP_K) ? w_j_row : w_k_row;
        w_mem_we    = !rst && !w_busy && i_state_ena && i_state_wea;
        w_mem_waddr = i_state_addra;
        w_mem_wdata = i_state_dina;
        if (w_busy) begin
            w_mem_we    = !rst && (r_state_q == c_S_EXEC) &&
                          (r_step_q == c_ST_WR_K || r_step_q == c_ST_WR_J);
            w_mem_waddr = (r_step_q == c_ST_WR_K) ? w_k_row : w_j_row;
            w_mem_wdata = (r_step_q == c_ST_WR_K) ? w_row_k_new : w_row_j_new;
        end
    end

    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state_q     <= c_S_IDLE;
            r_ctx_ptr_q   <= '0;
            r_fetch_cnt_q <= '0;
            r_qbit_num_q  <= '0;
            r_tgt_q       <= '0;
            r_ctl_q       <= '0;
            r_ctl_en_q    <= 1'b0;
            r_coef_q      <= '{default: '0};
            r_k_q         <= '0;
            r_step_q      <= c_ST_SCAN;
            r_row_k_q     <= '0;
            r_row_j_q     <= '0;
            r_complete_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ctx_ptr_q   <= w_ctx_ptr_d;
            r_fetch_cnt_q <= w_fetch_cnt_d;
            r_qbit_num_q  <= w_qbit_num_d;
            r_tgt_q       <= w_tgt_d;
            r_ctl_q       <= w_ctl_d;
            r_ctl_en_q    <= w_ctl_en_d;
            r_coef_q      <= w_coef_d;
            r_k_q         <= w_k_d;
            r_step_q      <= w_step_d;
            r_row_k_q     <= w_row_k_d;
            r_row_j_q     <= w_row_j_d;
            r_complete_q  <= w_complete_d;
        end
    end

    always_ff @(posedge clk) begin : p_state_ram
        if (w_mem_we) r_state_ram[w_mem_waddr] <= w_mem_wdata;
        r_eng_rd_q <= r_state_ram[w_eng_raddr];
    end

    always_ff @(posedge clk) begin : p_host_rd
        if (rst)                          r_dout_q <= '0;
        else if (!w_busy && i_state_ena)  r_dout_q <= r_state_ram[i_state_addra];
    end

    always_ff @(posedge clk) begin : p_ctx_ram
        if (w_ctx_we) r_ctx_ram[i_ctx_addr] <= i_ctx_data;
        r_ctx_rd_q <= r_ctx_ram[w_ctx_raddr];
    end

    assign o_complete   = r_complete_q;
    assign o_state_dout = r_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_qea_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_qea_engine
// Purpose  : Directed self-checking bench for qea_engine (n = 6, 16 rows).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qea_engine;
    localparam logic [63:0] c_ONE = 64'h40000000_00000000;
    localparam logic [63:0] c_HV  = 64'h2D413CCC_00000000;
    localparam logic [63:0] c_HN  = 64'hD2BEC334_00000000;
    localparam logic [63:0] c_IU  = 64'h00000000_40000000;
    localparam logic [63:0] c_Z   = 64'h0;
    localparam logic [255:0] c_PAT = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_11223344_55667788;

    logic         clk = 1'b0;
    logic         rst, i_start, i_ctx_en, i_ctx_wea, i_state_ena, i_state_wea;
    logic [5:0]   i_qbit_num;
    logic [15:0]  i_ctx_addr, i_state_addra;
    logic [63:0]  i_ctx_data;
    logic [255:0] i_state_dina, o_state_dout;
    logic         o_complete;
    int           checks = 0;
    int           failures = 0;

    qea_engine dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
        .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
        .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] row4(input logic [63:0] l0, l1, l2, l3);
        return {l0, l1, l2, l3};
    endfunction

    function automatic logic [63:0] hdr(input logic [5:0] t, input logic ce, input logic [5:0] c);
        return {4'h1, t, ce, c, 47'd0};
    endfunction

    task automatic ctx_wr(input logic [15:0] addr, input logic [63:0] data);
        @(negedge clk); i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = addr; i_ctx_data = data;
        @(negedge clk); i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
    endtask

    task automatic load_gate(input logic [15:0] base, input logic [5:0] t, input logic ce,
                             input logic [5:0] c, input logic [63:0] u00, u01, u10, u11);
        ctx_wr(base, hdr(t, ce, c));
        ctx_wr(base + 16'd1, u00);
        ctx_wr(base + 16'd2, u01);
        ctx_wr(base + 16'd3, u10);
        ctx_wr(base + 16'd4, u11);
    endtask

    task automatic state_wr(input logic [15:0] row, input logic [255:0] data);
        @(negedge clk); i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = row; i_state_dina = data;
        @(negedge clk); i_state_ena = 1'b0; i_state_wea = 1'b0;
    endtask

    task automatic read_row(input logic [15:0] row, output logic [255:0] data);
        @(negedge clk); i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = row;
        @(negedge clk); i_state_ena = 1'b0;
        data = o_state_dout;
    endtask

    task automatic clear_state();
        for (int r = 0; r < 16; r++) state_wr(16'(r), '0);
    endtask

    task automatic run_prog(input string tag, input bit mid_start, output int cyc);
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        check({tag, " cleared"}, 256'(o_complete), 256'(0));
        cyc = 1;
        while (!o_complete && cyc < 5000) begin
            @(negedge clk); cyc++;
            if (mid_start && cyc == 20) begin
                i_start = 1'b1; @(negedge clk); i_start = 1'b0; cyc++;
            end
        end
        check({tag, " complete"}, 256'(o_complete), 256'(1));
    endtask

    initial begin : p_stim
        logic [255:0] rd, acc;
        int           cyc;
        rst = 1'b1; i_start = 1'b0; i_qbit_num = 6'd6;
        i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
        i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
        repeat (3) @(negedge clk);
        check("reset complete", 256'(o_complete), 256'(0));
        check("reset dout", o_state_dout, '0);
        rst = 1'b0;

        // Hadamard on qubit 0 from |0>
        clear_state();
        state_wr(16'd0, row4(c_ONE, c_Z, c_Z, c_Z));
        load_gate(16'd0, 6'd0, 1'b0, 6'd0, c_HV, c_HV, c_HV, c_HN);
        ctx_wr(16'd5, 64'h0);
        run_prog("h0", 1'b0, cyc);
        read_row(16'd0, rd);
        check("h0 row0", rd, row4(c_HV, c_HV, c_Z, c_Z));
        acc = '0;
        for (int r = 1; r < 16; r++) begin read_row(16'(r), rd); acc |= rd; end
        check("h0 rows1-15", acc, '0);

        // Hadamard on |1> exercises the negative coefficient
        state_wr(16'd0, row4(c_Z, c_ONE, c_Z, c_Z));
        run_prog("h1", 1'b0, cyc);
        read_row(16'd0, rd);
        check("h1 row0", rd, row4(c_HV, c_HN, c_Z, c_Z));

        // X on qubit 5 crosses rows; a start pulse mid-run must be ignored
        clear_state();
        state_wr(16'd0, row4(c_ONE, c_Z, c_Z, c_Z));
        load_gate(16'd0, 6'd5, 1'b0, 6'd0, c_Z, c_ONE, c_ONE, c_Z);
        run_prog("x5", 1'b1, cyc);
        read_row(16'd8, rd);
        check("x5 row8", rd, row4(c_ONE, c_Z, c_Z, c_Z));
        read_row(16'd0, rd);
        check("x5 row0", rd, '0);

        // X t=0 then CNOT(c=0,t=1): |0> -> |1> -> |3>
        clear_state();
        state_wr(16'd0, row4(c_ONE, c_Z, c_Z, c_Z));
        load_gate(16'd0, 6'd0, 1'b0, 6'd0, c_Z, c_ONE, c_ONE, c_Z);
        load_gate(16'd5, 6'd1, 1'b1, 6'd0, c_Z, c_ONE, c_ONE, c_Z);
        ctx_wr(16'd10, 64'h0);
        run_prog("cnot", 1'b0, cyc);
        read_row(16'd0, rd);
        check("cnot row0", rd, row4(c_Z, c_Z, c_Z, c_ONE));

        // Phase i on amp1 = 1.0 + 0.5i -> -0.5 + 1.0i
        clear_state();
        state_wr(16'd0, row4(c_Z, 64'h40000000_20000000, c_Z, c_Z));
        load_gate(16'd0, 6'd0, 1'b0, 6'd0, c_ONE, c_Z, c_Z, c_IU);
        ctx_wr(16'd5, 64'h0);
        run_prog("phase", 1'b0, cyc);
        read_row(16'd0, rd);
        check("phase row0", rd, row4(c_Z, 64'hE0000000_40000000, c_Z, c_Z));

        // 0.5 * (-1 + 3i) LSB: floor gives -1 + 1i
        state_wr(16'd0, row4(64'hFFFFFFFF_00000003, c_Z, c_Z, c_Z));
        load_gate(16'd0, 6'd0, 1'b0, 6'd0, 64'h20000000_00000000, c_Z, c_Z, c_ONE);
        run_prog("trunc", 1'b0, cyc);
        read_row(16'd0, rd);
        check("trunc row0", rd, row4(64'hFFFFFFFF_00000001, c_Z, c_Z, c_Z));

        // Read-first host access, then hold
        state_wr(16'd3, c_PAT);
        @(negedge clk); i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'd3; i_state_dina = '0;
        @(negedge clk); i_state_ena = 1'b0; i_state_wea = 1'b0;
        check("rdfirst dout", o_state_dout, c_PAT);
        repeat (2) @(negedge clk);
        check("dout hold", o_state_dout, c_PAT);
        read_row(16'd3, rd);
        check("row3 after wr", rd, '0);

        // Empty program
        state_wr(16'd0, c_PAT);
        ctx_wr(16'd0, 64'h0);
        run_prog("empty", 1'b0, cyc);
        check("empty latency", 256'(cyc <= 4), 256'(1));
        repeat (3) @(negedge clk);
        check("complete held", 256'(o_complete), 256'(1));
        read_row(16'd0, rd);
        check("empty state", rd, c_PAT);

        // Reset during execution; a host write while busy must be dropped
        clear_state();
        state_wr(16'd0, row4(c_ONE, c_Z, c_Z, c_Z));
        load_gate(16'd0, 6'd5, 1'b0, 6'd0, c_Z, c_ONE, c_ONE, c_Z);
        ctx_wr(16'd5, 64'h0);
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        repeat (10) @(negedge clk);
        state_wr(16'd15, c_PAT);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst complete", 256'(o_complete), 256'(0));
        check("rst dout", o_state_dout, '0);
        rst = 1'b0;
        read_row(16'd15, rd);
        check("busy wr ignored", rd, '0);
        ctx_wr(16'd0, 64'h0);
        run_prog("post rst", 1'b0, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
